// File: rtl/prng_pkg.sv
// Shared definitions for the 16-bit Galois LFSR generator/checker pair.
package prng_pkg;

    localparam int PRNG_W = 16;
    localparam logic [PRNG_W-1:0] PRNG_POLY = 16'h00AF;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        SYNC    = 2'd1,
        LOCKED  = 2'd2
    } prng_chk_state_t;

    // One Galois step: shift left, fold the feedback mask in when the MSB falls out.
    function automatic logic [PRNG_W-1:0] prng_step(
        input logic [PRNG_W-1:0] d,
        input logic [PRNG_W-1:0] poly = PRNG_POLY
    );
        prng_step = {d[PRNG_W-2:0], 1'b0} ^ (d[PRNG_W-1] ? poly : {PRNG_W{1'b0}});
    endfunction

endpackage

// File: rtl/prng_checker_if.sv
// Received pseudo-random word stream: a qualifier plus the word itself.
interface prng_checker_if;
    import prng_pkg::*;

    logic              ivalid;
    logic [PRNG_W-1:0] din;

    modport master (output ivalid, output din);
    modport slave  (input  ivalid, input  din);

endinterface

// File: rtl/prng_lfsr_step.sv
// Combinational single step of the Galois LFSR; shared by generator and checker.
module prng_lfsr_step
    import prng_pkg::*;
#(
    parameter logic [PRNG_W-1:0] POLY = PRNG_POLY
) (
    input  logic [PRNG_W-1:0] d,
    output logic [PRNG_W-1:0] q
);

    assign q = prng_step(d, POLY);

endmodule

// File: rtl/prng_checker.sv
// Self-synchronising LFSR stream checker: seeds from the stream, confirms lock,
// then flywheels the expected word and counts mismatches.
module prng_checker
    import prng_pkg::*;
#(
    parameter logic [PRNG_W-1:0] POLY       = PRNG_POLY,
    parameter int                LOCK_CNT   = 4,
    parameter int                UNLOCK_CNT = 8,
    parameter int                CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iclr,
    prng_checker_if.slave        stream,
    output logic                 locked,
    output logic                 err,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     word_cnt
);

    localparam int MC_W = $clog2(LOCK_CNT) + 1;
    localparam int BR_W = $clog2(UNLOCK_CNT) + 1;
    localparam logic [MC_W-1:0] MC_LAST = MC_W'(LOCK_CNT - 1);
    localparam logic [BR_W-1:0] BR_LAST = BR_W'(UNLOCK_CNT - 1);

    prng_chk_state_t   state_r;
    logic [PRNG_W-1:0] exp_r;
    logic [MC_W-1:0]   match_cnt_r;
    logic [BR_W-1:0]   bad_run_r;
    logic              locked_r;
    logic              err_r;
    logic [CNT_W-1:0]  err_cnt_r;
    logic [CNT_W-1:0]  word_cnt_r;

    logic [PRNG_W-1:0] step_din_s;
    logic [PRNG_W-1:0] step_exp_s;
    logic              din_zero_s;
    logic              din_hit_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : v + CNT_W'(1);
    endfunction

    prng_lfsr_step #(.POLY(POLY)) u_step_din (.d(stream.din), .q(step_din_s));
    prng_lfsr_step #(.POLY(POLY)) u_step_exp (.d(exp_r),      .q(step_exp_s));

    assign din_zero_s = (stream.din == {PRNG_W{1'b0}});
    assign din_hit_s  = (stream.din == exp_r);

    // Acquisition/lock FSM with its counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ACQUIRE;
            exp_r       <= {PRNG_W{1'b0}};
            match_cnt_r <= {MC_W{1'b0}};
            bad_run_r   <= {BR_W{1'b0}};
            locked_r    <= 1'b0;
            err_r       <= 1'b0;
            err_cnt_r   <= {CNT_W{1'b0}};
            word_cnt_r  <= {CNT_W{1'b0}};
        end else if (iclr) begin
            state_r     <= ACQUIRE;
            match_cnt_r <= {MC_W{1'b0}};
            bad_run_r   <= {BR_W{1'b0}};
            locked_r    <= 1'b0;
            err_r       <= 1'b0;
            err_cnt_r   <= {CNT_W{1'b0}};
            word_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            err_r <= 1'b0;
            if (stream.ivalid) begin
                case (state_r)
                    ACQUIRE: begin
                        // All-zero is the LFSR lock-up word and cannot seed.
                        if (!din_zero_s) begin
                            exp_r       <= step_din_s;
                            match_cnt_r <= {MC_W{1'b0}};
                            state_r     <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (din_hit_s) begin
                            exp_r <= step_din_s;
                            if (match_cnt_r == MC_LAST) begin
                                state_r     <= LOCKED;
                                locked_r    <= 1'b1;
                                match_cnt_r <= {MC_W{1'b0}};
                                bad_run_r   <= {BR_W{1'b0}};
                            end else begin
                                match_cnt_r <= match_cnt_r + MC_W'(1);
                            end
                        end else if (din_zero_s) begin
                            state_r     <= ACQUIRE;
                            match_cnt_r <= {MC_W{1'b0}};
                        end else begin
                            exp_r       <= step_din_s;
                            match_cnt_r <= {MC_W{1'b0}};
                        end
                    end
                    LOCKED: begin
                        // Flywheel: expectation follows itself, never the received word.
                        exp_r      <= step_exp_s;
                        word_cnt_r <= sat_inc(word_cnt_r);
                        if (din_hit_s) begin
                            bad_run_r <= {BR_W{1'b0}};
                        end else begin
                            err_r     <= 1'b1;
                            err_cnt_r <= sat_inc(err_cnt_r);
                            if (bad_run_r == BR_LAST) begin
                                state_r   <= ACQUIRE;
                                locked_r  <= 1'b0;
                                bad_run_r <= {BR_W{1'b0}};
                            end else begin
                                bad_run_r <= bad_run_r + BR_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_r     <= ACQUIRE;
                        locked_r    <= 1'b0;
                        match_cnt_r <= {MC_W{1'b0}};
                        bad_run_r   <= {BR_W{1'b0}};
                    end
                endcase
            end
        end
    end

    assign locked   = locked_r;
    assign err      = err_r;
    assign err_cnt  = err_cnt_r;
    assign word_cnt = word_cnt_r;

endmodule

// File: tb/tb_prng_checker.sv
// Directed + randomized bench for prng_checker; two instances (16-bit and 4-bit counters) share one stream.
module tb_prng_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic iclr = 1'b0;

    prng_checker_if sif ();

    logic        locked_a, err_a;
    logic [15:0] err_cnt_a, word_cnt_a;
    logic        locked_b, err_b;
    logic [3:0]  err_cnt_b, word_cnt_b;

    prng_checker #(.CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .iclr(iclr), .stream(sif),
        .locked(locked_a), .err(err_a), .err_cnt(err_cnt_a), .word_cnt(word_cnt_a)
    );

    prng_checker #(.CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .iclr(iclr), .stream(sif),
        .locked(locked_b), .err(err_b), .err_cnt(err_cnt_b), .word_cnt(word_cnt_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: plain-arithmetic view of hunting / confirming / flywheel tracking.
    localparam int HUNT = 0, CONFIRM = 1, TRACK = 2;
    int m_mode, m_exp, m_hits, m_miss_run;
    int m_err, m_locked;
    int m_err_a, m_word_a, m_err_b, m_word_b;
    int gen;

    function automatic int nxt(input int d);
        return ((d * 2) % 65536) ^ ((d >= 32768) ? 175 : 0);
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_mode = HUNT; m_exp = 0; m_hits = 0; m_miss_run = 0;
        m_err = 0; m_locked = 0;
        m_err_a = 0; m_word_a = 0; m_err_b = 0; m_word_b = 0;
    endtask

    task automatic model_step(input bit c, input bit v, input int d);
        m_err = 0;
        if (c) begin
            m_mode = HUNT; m_hits = 0; m_miss_run = 0;
            m_err_a = 0; m_word_a = 0; m_err_b = 0; m_word_b = 0;
        end else if (v) begin
            if (m_mode == HUNT) begin
                if (d != 0) begin m_exp = nxt(d); m_hits = 0; m_mode = CONFIRM; end
            end else if (m_mode == CONFIRM) begin
                if (d == m_exp) begin
                    m_exp = nxt(d);
                    m_hits++;
                    if (m_hits == 4) begin m_mode = TRACK; m_miss_run = 0; end
                end else if (d == 0) begin
                    m_mode = HUNT;
                end else begin
                    m_exp = nxt(d); m_hits = 0;
                end
            end else begin
                m_word_a = sat(m_word_a, 65535);
                m_word_b = sat(m_word_b, 15);
                if (d == m_exp) begin
                    m_miss_run = 0;
                end else begin
                    m_err = 1;
                    m_err_a = sat(m_err_a, 65535);
                    m_err_b = sat(m_err_b, 15);
                    m_miss_run++;
                    if (m_miss_run == 8) begin m_mode = HUNT; m_miss_run = 0; end
                end
                m_exp = nxt(m_exp);
            end
        end
        m_locked = (m_mode == TRACK) ? 1 : 0;
    endtask

    task automatic check_all();
        chk("locked_a",   locked_a,   m_locked);
        chk("err_a",      err_a,      m_err);
        chk("err_cnt_a",  err_cnt_a,  m_err_a);
        chk("word_cnt_a", word_cnt_a, m_word_a);
        chk("locked_b",   locked_b,   m_locked);
        chk("err_b",      err_b,      m_err);
        chk("err_cnt_b",  err_cnt_b,  m_err_b);
        chk("word_cnt_b", word_cnt_b, m_word_b);
    endtask

    task automatic cycle(input bit c, input bit v, input int d);
        iclr = c;
        sif.ivalid = v;
        sif.din = 16'(d);
        @(posedge clk);
        model_step(c, v, d);
        #1;
        check_all();
    endtask

    task automatic good();
        cycle(1'b0, 1'b1, gen);
        gen = nxt(gen);
    endtask

    task automatic bad_word(input int d);
        cycle(1'b0, 1'b1, d);
        gen = nxt(gen);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_locked", locked_a, 32'd0);
        chk("rst_err_cnt_b", err_cnt_b, 32'd0);
        chk("rst_word_cnt_a", word_cnt_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        sif.ivalid = 1'b0;
        sif.din = 16'h0000;
        model_reset();
        #2;
        do_reset();

        // 1: lock on a clean stream seeded with 0001, then 100 locked words
        gen = 1;
        for (int i = 1; i <= 5; i++) begin
            good();
            chk("t1_lock_time", locked_a, (i == 5) ? 32'd1 : 32'd0);
        end
        repeat (100) good();
        chk("t1_word_cnt", word_cnt_a, 32'd100);
        chk("t1_err_cnt", err_cnt_a, 32'd0);

        // 2: single bit-3 flip costs exactly one error
        bad_word(gen ^ 32'h0008);
        chk("t2_err", err_a, 32'd1);
        chk("t2_err_cnt", err_cnt_a, 32'd1);
        chk("t2_locked", locked_a, 32'd1);
        good();
        chk("t2_flywheel", err_a, 32'd0);

        // 3: eight bad words in a row drop lock; clean stream relocks after five
        for (int i = 1; i <= 8; i++) begin
            bad_word(32'h1234);
            chk("t3_locked", locked_a, (i == 8) ? 32'd0 : 32'd1);
        end
        chk("t3_err_cnt", err_cnt_a, 32'd9);
        for (int i = 1; i <= 5; i++) begin
            good();
            chk("t3_relock", locked_a, (i == 5) ? 32'd1 : 32'd0);
        end

        // 4: zeros ignored in ACQUIRE, then gapped stream still locks
        cycle(1'b1, 1'b0, 0);
        repeat (3) cycle(1'b0, 1'b1, 0);
        cycle(1'b0, 1'b1, 32'h8000);
        cycle(1'b0, 1'b1, 32'h00AF);
        chk("t4_not_locked", locked_a, 32'd0);
        gen = 32'h015E;
        for (int i = 1; i <= 3; i++) begin
            idle();
            idle();
            good();
            chk("t4_gap_lock", locked_a, (i == 3) ? 32'd1 : 32'd0);
        end

        // 5: iclr with ivalid drops the word and clears; async reset mid-SYNC
        repeat (5) begin
            bad_word(gen ^ 32'h0040);
            good();
        end
        chk("t5_err_cnt5", err_cnt_a, 32'd5);
        cycle(1'b1, 1'b1, gen);
        gen = nxt(gen);
        chk("t5_clr_locked", locked_a, 32'd0);
        chk("t5_clr_err_cnt", err_cnt_a, 32'd0);
        good();
        good();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            good();
            chk("t5_reseed", locked_a, (i == 5) ? 32'd1 : 32'd0);
        end

        // 6: 4-bit counters saturate while lock holds under isolated errors
        cycle(1'b1, 1'b0, 0);
        repeat (5) good();
        for (int i = 0; i < 20; i++) begin
            bad_word(gen ^ 32'h0100);
            chk("t6_err_pulse", err_b, 32'd1);
            good();
        end
        chk("t6_err_cnt_sat", err_cnt_b, 32'd15);
        chk("t6_locked", locked_b, 32'd1);
        chk("t6_err_cnt_wide", err_cnt_a, 32'd20);
        do_reset();

        // Randomized traffic against the model
        gen = $urandom_range(1, 65535);
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2)       cycle(1'b1, 1'($urandom_range(0, 1)), gen);
            else if (r < 25) idle();
            else if (r < 33) bad_word($urandom_range(0, 65535));
            else             good();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
